add_serial_byte: RTL

//   Multi-cycle wide adder that time-multiplexes one add_8_bit slice.

---
 rtl/add_serial_byte.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/add_serial_byte.sv
// add_serial_byte: a multi-cycle wide adder. Both operands are latched on an
// accepted start. One shared add_8_bit slice then takes one byte per cycle,
// starting with the least significant byte. The carry between bytes is formed
// from the slice's generate and propagate outputs.
// Optional build macro: ADD_SERIAL_SUB_EN. When it is defined, the module gets
// a 'sub' port and can also subtract.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; s/c_out/ovf hold the previous result
// ST_RUN  | one byte slice summed and written per cycle, LSB first
// ST_DONE | result valid, done pulses for exactly this cycle

// add_8_bit: an 8-bit ripple slice. It also exports group generate and
// group propagate, so the caller can form the carry out of the byte.
module add_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] s,
  output logic       g_out,
  output logic       p_out
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [7:0] w_c;
  logic       w_gg;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Ripple the carry through the byte. Also fold the group generate, which is
  // the carry out of the byte when c_in is zero.
  always_comb begin
    w_c    = '0;
    w_c[0] = c_in;
    for (int i = 0; i < 7; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
    w_gg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_gg = w_g[i] | (w_p[i] & w_gg);
    end
  end

  assign s     = w_p ^ w_c;
  assign g_out = w_gg;
  assign p_out = &w_p;

endmodule

module add_serial_byte #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*BYTES-1:0] a,
  input  logic [8*BYTES-1:0] b,
  input  logic               c_in,
`ifdef ADD_SERIAL_SUB_EN
  input  logic               sub,
`endif
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] s,
  output logic               c_out,
  output logic               ovf
);

  localparam int W  = 8 * BYTES;
  localparam int IW = $clog2(BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [W-1:0]    r_s;
  logic            r_c_out;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [7:0]      w_sum_byte;
  logic            w_g;
  logic            w_p;
  logic            w_carry_next;
  logic            w_msb_cin;
  logic [W-1:0]    w_b_load;
  logic            w_carry_load;

  // Choose the operand B value and the initial carry to latch on start. When
  // subtracting, B is inverted and the carry is forced to 1 (two's complement).
`ifdef ADD_SERIAL_SUB_EN
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_load = sub ? 1'b1 : c_in;
`else
  assign w_b_load     = b;
  assign w_carry_load = c_in;
`endif

  assign w_a_byte = r_a[8*r_idx +: 8];
  assign w_b_byte = r_b[8*r_idx +: 8];

  add_8_bit u_slice (
    .a     (w_a_byte),
    .b     (w_b_byte),
    .c_in  (r_carry),
    .s     (w_sum_byte),
    .g_out (w_g),
    .p_out (w_p)
  );

  assign w_carry_next = w_g | (w_p & r_carry);

  // This is the carry into the MSB of the whole word. It is recovered from the
  // sum bit: s = a ^ b ^ cin. It is only meaningful while the top slice is
  // being processed.
  assign w_msb_cin = r_a[W-1] ^ r_b[W-1] ^ w_sum_byte[7];

  // Sequencer: latch on start, step one slice per cycle, pulse done, return to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_carry_load;
            r_idx   <= '0;
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s[8*r_idx +: 8] <= w_sum_byte;
          r_carry           <= w_carry_next;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_c_out <= w_carry_next;
            r_ovf   <= w_carry_next ^ w_msb_cin;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign s     = r_s;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule
